uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range is 4 or more.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning the FIFO holds 2^DEPTH_LOG2 bytes.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rdreq  input  1  consumer pop request.
REQ-007 empty  output  1  high when the FIFO holds no bytes.
REQ-008 q  output  8  popped byte.
REQ-009 overrun  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-010 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all receive logic SHALL use only the synchronized value.
REQ-012 SHALL implement the receive FSM with states IDLE, START, DATA and STOP.
- IDLE -> START on a synchronized high-to-low transition.
- START: sample at CLKS_PER_BIT/2 (integer division). Low -> DATA. High -> IDLE (glitch rejected, nothing stored).
- DATA: sample 8 bits, one every CLKS_PER_BIT cycles, shifting LSB first; after bit 7 -> STOP.
- STOP: sample after CLKS_PER_BIT cycles, then -> IDLE in the next cycle.
REQ-013 SHALL count baud cycles with a counter wide enough for CLKS_PER_BIT-1; it resets to 0 on every state change.
REQ-014 SHALL push the assembled byte in the cycle after the stop-bit sample, provided the stop bit is accepted (REQ-026/027) and the FIFO is not full.
REQ-015 If a byte arrives while the FIFO is full and rdreq is not active in that cycle, SHALL discard it and pulse overrun for exactly one cycle; FIFO contents stay unchanged.
REQ-016 If the FIFO is full and rdreq is active in the same cycle as the push, SHALL perform both pop and push; count unchanged, no overrun.
REQ-017 The FIFO SHALL operate in normal (not show-ahead) mode: on an edge with rdreq=1 and empty=0, q takes the oldest byte and that byte is removed. Otherwise q holds its value.
REQ-018 rdreq while empty SHALL be ignored: q, pointers and count unchanged.
REQ-019 A push and a pop in the same cycle while empty: the pop is ignored, the push is stored, and empty deasserts after that edge.
REQ-020 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2. The count SHALL be DEPTH_LOG2+1 bits.
REQ-021 empty SHALL be registered and SHALL fall on the same edge that writes the first byte, i.e. 2 cycles after the stop-bit sample.
REQ-022 SHALL accept a new start bit in the cycle after the return to IDLE, so back-to-back frames are supported.

Reset
REQ-023 While rst_n=0: FSM in IDLE, counters 0, pointers 0, count 0, synchronizer flops set to 1.
REQ-024 While rst_n=0: empty=1, q=8'h00, overrun=0, frame_err=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; no partial byte is ever stored. After release, reception waits for a new falling edge.

Configuration
REQ-026 With UART_RX_FRAME_CHECK_EN defined: a byte whose stop bit samples low SHALL be discarded, and frame_err pulses for one cycle.
REQ-027 Without UART_RX_FRAME_CHECK_EN: every byte SHALL be stored regardless of the stop-bit value, and frame_err is tied to 0.

Verification
REQ-028 CLKS_PER_BIT=8, send 8'hA5 with a valid stop bit -> empty falls 2 cycles after the stop sample; pulse rdreq -> q=8'hA5 next edge, empty=1.
REQ-029 DEPTH_LOG2=2, send 5 bytes 8'h01..8'h05 with no reads -> overrun pulses once on byte 5; 4 pops return 8'h01..8'h04 in order.
REQ-030 Low pulse on rxd of 2 cycles (CLKS_PER_BIT=8) -> FSM returns to IDLE, empty stays 1, no pulses.
REQ-031 Macro defined, send 8'h3C with the stop bit held low -> frame_err pulses once, empty stays 1. Macro undefined -> q=8'h3C after a pop.
REQ-032 Assert rst_n=0 during bit 4 of a frame, release, then send 8'h7E -> only 8'h7E is received; rdreq while empty leaves q unchanged.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a normal-mode (registered q) byte FIFO.
// Optional macro UART_RX_FRAME_CHECK_EN: drop bytes with a low stop bit, pulse frame_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rdreq,
    output logic       empty,
    output logic [7:0] q,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CW-1:0]         C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]         C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic                  w_rx;
    logic                  w_fall;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  r_stop_smp;
    logic                  r_push;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  r_empty;
    logic [7:0]            r_q;
    logic                  r_overrun;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_ovr;

    assign w_rx   = r_sync2;
    assign w_fall = r_prev & ~r_sync2;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    logic r_stop_bit;
    logic r_ferr;

    // Latch the stop-bit sample so the push decision can see it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop_bit <= 1'b0;
        end else if (r_state == S_STOP && !r_stop_smp && r_cnt == C_LAST) begin
            r_stop_bit <= w_rx;
        end
    end

    // Frame error pulse issued alongside the (suppressed) push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ferr <= 1'b0;
        end else begin
            r_ferr <= (r_state == S_STOP) && r_stop_smp && !r_stop_bit;
        end
    end

    assign frame_err = r_ferr;
`else
    assign frame_err = 1'b0;
`endif

    // Receive FSM: start validation, 8 data bits LSB first, stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= 3'd0;
            r_shift    <= 8'h00;
            r_stop_smp <= 1'b0;
            r_push     <= 1'b0;
        end else begin
            r_push <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_state <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_stop_smp) begin
                        r_stop_smp <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                        r_push     <= r_stop_bit;
`else
                        r_push     <= 1'b1;
`endif
                    end else if (r_cnt == C_LAST) begin
                        r_stop_smp <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_full = (r_count == C_FULL);
    assign w_pop  = rdreq & ~r_empty;
    assign w_wr   = r_push & (~w_full | w_pop);
    assign w_ovr  = r_push & w_full & ~rdreq;

    // Occupancy after this edge's push and pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(1);
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - (DEPTH_LOG2 + 1)'(1);
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // FIFO pointers, count, registered read data and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_q       <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
                r_q    <= r_mem[r_rptr];
            end
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_overrun <= w_ovr;
        end
    end

    assign empty   = r_empty;
    assign q       = r_q;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo (CLKS_PER_BIT=8, 4-deep FIFO).
// Expected bytes come from a queue model of the serial frames sent.
module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef UART_RX_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxd = 1'b1;
    logic       rdreq = 1'b0;
    logic       empty;
    logic [7:0] q;
    logic       overrun;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int n_ovr = 0;
    int n_fe = 0;
    int exp_ovr = 0;
    int exp_fe = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q = 8'h00;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH_LOG2  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rdreq    (rdreq),
        .empty    (empty),
        .q        (q),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun === 1'b1) n_ovr++;
        if (frame_err === 1'b1) n_fe++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop);
        if (FCHK && !stop) exp_fe++;
        else if (mq.size() == DEPTH) exp_ovr++;
        else mq.push_back(b);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        send_bits(b, stop);
        model_rx(b, stop);
        repeat (3) @(negedge clk);
    endtask

    task automatic pop(input string tag);
        @(negedge clk) rdreq = 1'b1;
        @(negedge clk) rdreq = 1'b0;
        if (mq.size() != 0) exp_q = mq.pop_front();
        chk({tag, "_q"}, 32'(q), 32'(exp_q));
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_bits(8'hA5, 1'b1);
        chk("a5_empty_smp", 32'(empty), 32'd1);
        @(negedge clk);
        chk("a5_empty_p1", 32'(empty), 32'd1);
        @(negedge clk);
        chk("a5_empty_p2", 32'(empty), 32'd0);
        model_rx(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        pop("a5");

        @(negedge clk) rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_empty", 32'(empty), 32'd1);
        chk("glitch_ovr", 32'(n_ovr), 32'(exp_ovr));
        chk("glitch_fe", 32'(n_fe), 32'(exp_fe));

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        chk("ovr_cnt", 32'(n_ovr), 32'(exp_ovr));
        chk("ovr_once", 32'(exp_ovr), 32'd1);
        for (int i = 0; i < 4; i++) pop("ovr_pop");

        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1);
        send_bits(8'h14, 1'b1);
        @(negedge clk) rdreq = 1'b1;
        @(negedge clk) rdreq = 1'b0;
        exp_q = mq.pop_front();
        mq.push_back(8'h14);
        chk("full_rw_q", 32'(q), 32'(exp_q));
        chk("full_rw_ovr", 32'(n_ovr), 32'(exp_ovr));
        chk("full_rw_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 4; i++) pop("full_rw_pop");

        send(8'h3C, 1'b0);
        chk("fe_cnt", 32'(n_fe), 32'(exp_fe));
        chk("fe_empty", 32'(empty), 32'(mq.size() == 0));
        pop("fe_pop");

        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            logic       s;
            int         np;
            b  = 8'($urandom);
            s  = ($urandom_range(0, 7) != 0);
            np = $urandom_range(0, 2);
            send(b, s);
            for (int j = 0; j < np; j++) pop("rnd_pop");
        end
        chk("rnd_ovr", 32'(n_ovr), 32'(exp_ovr));
        chk("rnd_fe", 32'(n_fe), 32'(exp_fe));
        while (mq.size() != 0) pop("rnd_drain");

        @(negedge clk) rxd = 1'b0;
        repeat (CPB * 5 + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        mq.delete();
        exp_q = 8'h00;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_q", 32'(q), 32'h00);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_empty", 32'(empty), 32'd1);
        send(8'h7E, 1'b1);
        pop("7e");
        pop("7e_empty_rd");
        chk("end_ovr", 32'(n_ovr), 32'(exp_ovr));
        chk("end_fe", 32'(n_fe), 32'(exp_fe));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
